rvfi_commit_serializer: RTL
===========================

# rvfi_commit_serializer

Sits between the core's multi-port RVFI commit bus and single-stream trace consumers, such as the tracer, DPI logging and the co-simulation checker. Each cycle it buffers every retired entry from `NR_COMMIT_PORTS` commit ports into a FIFO. It replays the entries one per handshake in program order (ascending port index within a cycle). It also detects the tohost termination store and sequences end-of-test: stop accepting, drain, then signal exit.

## Interface
Parameters:
- `NR_COMMIT_PORTS`, default 2: number of RVFI commit ports.
- `DEPTH`, default 16: FIFO entries; power of two, at least 2*`NR_COMMIT_PORTS`.

Ports:
- `clk_i` input, 1: clock.
- `rst_i` input, 1: reset; asynchronous and active-high.
- `rvfi_i` input, `rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]`: commit ports.
- `tohost_addr_i` input, `riscv::XLEN`: tohost address; 0 disables termination detection.
- `out_valid_o` output, 1: head entry available.
- `out_ready_i` input, 1: consumer accepts the head entry.
- `out_o` output, `rvfi_pkg::rvfi_instr_t`: head entry.
- `out_port_o` output, `$clog2(NR_COMMIT_PORTS)` (minimum 1): source port of the head entry.
- `level_o` output, `$clog2(DEPTH)+1`: current occupancy.
- `overflow_o` output, 1: sticky; at least one entry was dropped.
- `drop_cnt_o` output, 32: dropped-entry count; saturates at 32'hFFFF_FFFF.
- `exit_valid_o` output, 1: sticky; end of test reached and drained.
- `exit_code_o` output, 64: captured tohost `mem_wdata`.

## Operation
- **Eligible entry:** port i with `rvfi_i[i].valid`. The trap extension is covered under Configuration.
- **Enqueue order:**
  - Eligible entries are written to consecutive slots in ascending port order.
  - Non-eligible ports leave no holes.
- **Capacity:**
  - free = `DEPTH` - `level_o`, sampled at the start of the cycle.
  - A same-cycle dequeue does not create room.
  - Only the lowest-indexed free eligible entries are written.
  - The rest are dropped. Each drop increments `drop_cnt_o`, and `overflow_o` is set.
- **Pointers:** wrap modulo `DEPTH`. `level_o` = enqueued - dequeued, updated once per cycle.
- **Dequeue:**
  - `out_valid_o` = (`level_o` != 0).
  - A transfer occurs when `out_valid_o` and `out_ready_i` are both high.
  - `out_o` and `out_port_o` stay stable while valid is high and ready is low.
- **Termination match:** the entry is eligible, `rd_addr`==0, `mem_wmask`!=0, `mem_addr`==`tohost_addr_i`, `tohost_addr_i`!=0 and `mem_wdata`!=0.
- **FSM:**
  - RUN: accept entries. A matching entry that is actually enqueued:
    - captures `exit_code_o`;
    - blocks all higher-indexed ports in the same cycle (not enqueued, not counted as drops);
    - moves the FSM to DRAIN.
    - A matching entry that is dropped for lack of room does not terminate.
  - DRAIN: enqueue nothing and count no drops. Go to DONE in the cycle after `level_o` reaches 0.
  - DONE: `exit_valid_o`=1. Nothing is enqueued. Leave only via reset.
- **Reset:** asserting reset at any time empties the FIFO, clears pointers, counters and sticky flags, and returns the FSM to RUN.

## Timing
- **Reset values:**
  - `out_valid_o`=0, `out_o`='0, `out_port_o`=0, `level_o`=0.
  - `overflow_o`=0, `drop_cnt_o`=0, `exit_valid_o`=0, `exit_code_o`=0.
- **Latency:** an entry enqueued at edge N is visible on `out_o` after edge N when the FIFO was empty (one-cycle latency). There is no combinational path from `rvfi_i` to outputs.
- **Throughput:** one dequeue per cycle. Up to `NR_COMMIT_PORTS` enqueues per cycle.
- **Full:** with `level_o`==`DEPTH` and dequeue and eligible input in the same cycle, the input is dropped and `level_o` becomes `DEPTH`-1.
- **Exit:** `exit_valid_o` rises one cycle after the cycle in which the last entry (the tohost store) is transferred.
- All outputs are registered or driven from registered state.

## Configuration
- `RVFI_SERIALIZER_TRAP_EN`:
  - **Defined:** an entry with `valid`=0 and `trap`=1 is also eligible and is stored as-is, so consumers can log exceptions. Such an entry never matches termination.
  - **Undefined:** only `valid` entries are eligible and trap-only entries are ignored.

## Test plan
- **Ordering:** ports 0 and 1 valid on the same cycle with PCs 0x80000000/0x80000004, `out_ready_i`=1. Required: out PCs appear in the order ...000, ...004 on consecutive cycles, with `out_port_o` 0 then 1.
- **Holes and backpressure:** only port 1 valid (pc 0x100), `out_ready_i`=0 for 5 cycles. Required: `out_o` stays pc 0x100, `out_port_o`=1, `level_o`=1 throughout.
- **Overflow:** `DEPTH`=16, ready held 0, 9 cycles of both ports valid (18 entries). Required: `level_o`=16, `drop_cnt_o`=2, `overflow_o`=1. Then release ready: exactly 16 entries emerge, in order.
- **Termination:**
  - Setup: `tohost_addr_i`=0x80001000; port 0 commits sd with `mem_wdata`=1 to that address, port 1 valid in the same cycle; 3 entries already buffered.
  - Required: port 1 is not enqueued and `drop_cnt_o` is unchanged. The 4 entries drain. `exit_valid_o`=1 with `exit_code_o`=1 the cycle after the 4th transfer. Later input is ignored.
- **Reset mid-DRAIN:** assert `rst_i` asynchronously. Required: all outputs immediately 0, and normal operation resumes after release.
- **Trap handling:** with the macro defined, `valid`=0, `trap`=1 on port 0. Required: one entry emerges with `trap`=1. Without the macro: `level_o` stays 0.

Source files
------------

// File: rtl/riscv.sv
// Minimal architectural constants used by the trace path.
package riscv;
  localparam int unsigned XLEN = 64;
endpackage

// File: rtl/rvfi_pkg.sv
// RVFI retirement record carried on each commit port.
package rvfi_pkg;
  typedef struct packed {
    logic                      valid;
    logic [63:0]               order;
    logic [31:0]               insn;
    logic                      trap;
    logic                      halt;
    logic                      intr;
    logic [riscv::XLEN-1:0]    cause;
    logic [1:0]                mode;
    logic [4:0]                rs1_addr;
    logic [4:0]                rs2_addr;
    logic [4:0]                rd_addr;
    logic [riscv::XLEN-1:0]    rs1_rdata;
    logic [riscv::XLEN-1:0]    rs2_rdata;
    logic [riscv::XLEN-1:0]    rd_wdata;
    logic [riscv::XLEN-1:0]    pc_rdata;
    logic [riscv::XLEN-1:0]    pc_wdata;
    logic [riscv::XLEN-1:0]    mem_addr;
    logic [riscv::XLEN/8-1:0]  mem_rmask;
    logic [riscv::XLEN/8-1:0]  mem_wmask;
    logic [riscv::XLEN-1:0]    mem_rdata;
    logic [riscv::XLEN-1:0]    mem_wdata;
  } rvfi_instr_t;
endpackage

// File: rtl/rvfi_commit_serializer.sv
// Serializes multi-port RVFI commits into one in-order stream and sequences tohost end-of-test.
// Define RVFI_SERIALIZER_TRAP_EN to also buffer trap-only (valid=0, trap=1) entries.
module rvfi_commit_serializer
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16,
  localparam int unsigned PortW  = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1,
  localparam int unsigned AddrW  = $clog2(DEPTH),
  localparam int unsigned LevelW = AddrW + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_i,
  input  logic [riscv::XLEN-1:0]              tohost_addr_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output rvfi_instr_t                         out_o,
  output logic [PortW-1:0]                    out_port_o,
  output logic [LevelW-1:0]                   level_o,
  output logic                                overflow_o,
  output logic [31:0]                         drop_cnt_o,
  output logic                                exit_valid_o,
  output logic [63:0]                         exit_code_o
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  rvfi_instr_t      mem_q      [DEPTH];
  logic [PortW-1:0] port_mem_q [DEPTH];

  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q, level_d;
  state_e            state_q, state_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;
  logic [63:0]       exit_code_q, exit_code_d;

  logic [NR_COMMIT_PORTS-1:0] we;
  logic [AddrW-1:0]           widx [NR_COMMIT_PORTS];
  logic [LevelW-1:0]          free, enq_cnt, drops;
  logic [32:0]                drop_sum;
  logic                       blocked, term_hit, deq;

  function automatic logic eligible(input rvfi_instr_t e);
`ifdef RVFI_SERIALIZER_TRAP_EN
    return e.valid | e.trap;
`else
    return e.valid;
`endif
  endfunction

  // Trap-only entries never match because valid is required here.
  function automatic logic is_term(input rvfi_instr_t e, input logic [riscv::XLEN-1:0] addr);
    return e.valid && (e.rd_addr == '0) && (|e.mem_wmask) && (e.mem_addr == addr) &&
           (|addr) && (|e.mem_wdata);
  endfunction

  assign deq = (level_q != '0) && out_ready_i;

  always_comb begin
    free        = LevelW'(DEPTH) - level_q;
    enq_cnt     = '0;
    drops       = '0;
    blocked     = 1'b0;
    term_hit    = 1'b0;
    exit_code_d = exit_code_q;
    we          = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) widx[i] = '0;
    if (state_q == StRun) begin
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (!blocked && eligible(rvfi_i[i])) begin
          if (enq_cnt < free) begin
            we[i]   = 1'b1;
            widx[i] = wr_ptr_q + enq_cnt[AddrW-1:0];
            enq_cnt = enq_cnt + LevelW'(1);
            if (is_term(rvfi_i[i], tohost_addr_i)) begin
              term_hit    = 1'b1;
              blocked     = 1'b1;
              exit_code_d = rvfi_i[i].mem_wdata;
            end
          end else begin
            drops = drops + LevelW'(1);
          end
        end
      end
    end
    level_d    = level_q + enq_cnt - LevelW'(deq);
    drop_sum   = {1'b0, drop_cnt_q} + 33'(drops);
    drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    overflow_d = overflow_q | (drops != '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (term_hit) state_d = StDrain;
      StDrain: if (level_d == '0) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (we[i]) begin
        mem_q[widx[i]]      <= rvfi_i[i];
        port_mem_q[widx[i]] <= PortW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= StRun;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      exit_code_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_q + enq_cnt[AddrW-1:0];
      rd_ptr_q    <= rd_ptr_q + AddrW'(deq);
      level_q     <= level_d;
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      exit_code_q <= exit_code_d;
    end
  end

  // Head is gated so an empty FIFO presents zeros regardless of stale storage.
  assign out_valid_o  = (level_q != '0);
  assign out_o        = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign out_port_o   = out_valid_o ? port_mem_q[rd_ptr_q] : '0;
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign exit_valid_o = (state_q == StDone);
  assign exit_code_o  = exit_code_q;

endmodule
